// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: sequences the NS/EW lamp phases for a crossing.
// It requests 10 s / 20 s intervals from an external timer and advances on
// the timer's done pulses. A watchdog latches a terminal FAULT (all red) if
// the timer stops answering.
// Optional feature macro: TPC_EMERGENCY_EN adds the 'emergency' input.
// While 'emergency' is held, the lamps stay all red; on release the cycle
// restarts at NS green.
module traffic_phase_ctrl #(
  parameter logic [31:0] WDOG_CYCLES = 32'd2_100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
`ifdef TPC_EMERGENCY_EN
  input  logic       emergency,
`endif
  input  logic       done_10s,
  input  logic       done_20s,
  output logic       start_10s,
  output logic       start_20s,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       fault,
  output logic [7:0] round_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    FAULT = 3'd5
`ifdef TPC_EMERGENCY_EN
    ,
    EMERG = 3'd6
`endif
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t      state;
  state_t      next_state;
  logic        waiting;
  logic        waiting_next;
  logic [31:0] wdog_cnt;
  logic [31:0] wdog_next;
  logic        expire;
  logic        round_inc;
  logic        start_10s_next;
  logic        start_20s_next;
  logic [2:0]  ns_next;
  logic [2:0]  ew_next;

  function automatic logic is_green(input state_t s);
    return (s == NS_G) || (s == EW_G);
  endfunction

  function automatic logic is_yellow(input state_t s);
    return (s == NS_Y) || (s == EW_Y);
  endfunction

  // The watchdog fires on the edge where the waiting-cycle count would reach the limit.
  assign expire = waiting && ((wdog_cnt + 32'd1) >= WDOG_CYCLES);

  // Next-state selection: watchdog beats emergency, which beats the phase's own done.
  always_comb begin
    next_state = state;
    round_inc  = 1'b0;
    if (expire) begin
      next_state = FAULT;
    end
`ifdef TPC_EMERGENCY_EN
    else if (emergency && (state != FAULT)) begin
      next_state = EMERG;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (enable) next_state = NS_G;
        end
        NS_G: begin
          if (waiting && done_20s) next_state = NS_Y;
        end
        NS_Y: begin
          if (waiting && done_10s) next_state = EW_G;
        end
        EW_G: begin
          if (waiting && done_20s) next_state = EW_Y;
        end
        EW_Y: begin
          if (waiting && done_10s) begin
            round_inc  = 1'b1;
            next_state = enable ? NS_G : IDLE;
          end
        end
        FAULT: begin
          next_state = FAULT;
        end
`ifdef TPC_EMERGENCY_EN
        EMERG: begin
          next_state = NS_G;
        end
`endif
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Decode lamps, entry pulses and watchdog bookkeeping from the state being entered.
  always_comb begin
    ns_next = LAMP_RED;
    ew_next = LAMP_RED;
    case (next_state)
      NS_G:    ns_next = LAMP_GREEN;
      NS_Y:    ns_next = LAMP_YELLOW;
      EW_G:    ew_next = LAMP_GREEN;
      EW_Y:    ew_next = LAMP_YELLOW;
      default: begin end
    endcase
    start_20s_next = is_green(next_state)  && (next_state != state);
    start_10s_next = is_yellow(next_state) && (next_state != state);
    waiting_next   = (is_green(next_state) || is_yellow(next_state)) &&
                     (next_state == state);
    wdog_next = 32'd0;
    if (waiting_next && waiting) wdog_next = wdog_cnt + 32'd1;
  end

  // Register the state together with every output so the lamps change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waiting   <= 1'b0;
      wdog_cnt  <= 32'd0;
      start_10s <= 1'b0;
      start_20s <= 1'b0;
      ns_light  <= LAMP_RED;
      ew_light  <= LAMP_RED;
      fault     <= 1'b0;
      round_cnt <= 8'd0;
    end else begin
      state     <= next_state;
      waiting   <= waiting_next;
      wdog_cnt  <= wdog_next;
      start_10s <= start_10s_next;
      start_20s <= start_20s_next;
      ns_light  <= ns_next;
      ew_light  <= ew_next;
      fault     <= (next_state == FAULT);
      round_cnt <= round_inc ? (round_cnt + 8'd1) : round_cnt;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Testbench for traffic_phase_ctrl.
// Contains an interval-timer stand-in, a phase-level reference model of the
// lamp controller, directed scenarios and a randomized stretch.
// Emergency scenarios are included when TPC_EMERGENCY_EN is defined.
module tb_traffic_phase_ctrl;

  localparam logic [31:0] WDOG       = 32'd50;
  localparam int          WDOG_LIMIT = 50;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_FAULT = 2;
  localparam int MODE_EMERG = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
`ifdef TPC_EMERGENCY_EN
  logic       emergency = 1'b0;
`endif
  logic       done_10s = 1'b0;
  logic       done_20s = 1'b0;
  logic       start_10s;
  logic       start_20s;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       fault;
  logic [7:0] round_cnt;

  int checks   = 0;
  int failures = 0;

  // timer stand-in controls
  int dur10    = 10;
  int dur20    = 20;
  bit timer_en = 1'b1;
  bit echo20   = 1'b0;
  bit noise10  = 1'b0;
  bit noise_en = 1'b0;

  // reference model state
  int m_mode    = MODE_IDLE;
  int m_phase   = 0;
  int m_age     = 0;
  int m_rounds  = 0;
  bit m_entered = 1'b0;
  bit m_valid   = 1'b0;

  traffic_phase_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
`ifdef TPC_EMERGENCY_EN
    .emergency (emergency),
`endif
    .done_10s  (done_10s),
    .done_20s  (done_20s),
    .start_10s (start_10s),
    .start_20s (start_20s),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .fault     (fault),
    .round_cnt (round_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en);
    rst    = r;
    enable = en;
    @(negedge clk);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitLamps(input logic [2:0] ns, input logic [2:0] ew,
                           input int budget, input string name);
    int i;
    i = 0;
    while (!((ns_light === ns) && (ew_light === ew)) && (i < budget)) begin
      @(negedge clk);
      i++;
    end
    checkOutput(name, {26'd0, ns_light, ew_light}, {26'd0, ns, ew});
  endtask

  function automatic logic [2:0] lampFor(input int side);
    if (m_mode == MODE_RUN && m_phase == 2 * side)     return 3'b001;
    if (m_mode == MODE_RUN && m_phase == 2 * side + 1) return 3'b010;
    return 3'b100;
  endfunction

  // Interval timer: done arrives in the last cycle of a dur-cycle phase.
  initial begin : timerModel
    int  t10;
    int  t20;
    bit  d10;
    bit  d20;
    t10 = 0;
    t20 = 0;
    forever begin
      @(negedge clk);
      d10 = 1'b0;
      d20 = 1'b0;
      if (start_20s === 1'b1) t20 = dur20;
      if (start_10s === 1'b1) t10 = dur10;
      if (t20 > 0) begin
        t20--;
        if (t20 == 0 && timer_en) d20 = 1'b1;
      end
      if (t10 > 0) begin
        t10--;
        if (t10 == 0 && timer_en) d10 = 1'b1;
      end
      if (echo20 && start_20s === 1'b1) d20 = 1'b1;
      if (noise10 && ns_light === 3'b001) d10 = 1'b1;
      if (noise_en) begin
        if ($urandom_range(15) == 0) d10 = 1'b1;
        if ($urandom_range(15) == 0) d20 = 1'b1;
      end
      done_10s = d10;
      done_20s = d20;
    end
  end

  // Reference model: phase index 0..3 plus time spent in the phase.
  always @(posedge clk) begin : refModel
    int mode;
    int phase;
    int age;
    int rounds;
    int agePrev;
    bit entered;
    bit dn;
    mode    = m_mode;
    phase   = m_phase;
    age     = m_age;
    rounds  = m_rounds;
    entered = 1'b0;
    if (rst === 1'b1) begin
      mode   = MODE_IDLE;
      rounds = 0;
      age    = 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      agePrev = age;
      age     = age + 1;
      dn      = (phase % 2 == 0) ? (done_20s === 1'b1) : (done_10s === 1'b1);
      if (mode == MODE_RUN && agePrev >= WDOG_LIMIT) begin
        mode = MODE_FAULT;
      end
`ifdef TPC_EMERGENCY_EN
      else if (emergency === 1'b1 && mode != MODE_FAULT) begin
        mode = MODE_EMERG;
      end
`endif
      else if (mode == MODE_IDLE) begin
        if (enable === 1'b1) begin
          mode = MODE_RUN; phase = 0; age = 0; entered = 1'b1;
        end
      end else if (mode == MODE_RUN) begin
        if (agePrev >= 1 && dn) begin
          if (phase == 3) begin
            rounds = (rounds + 1) % 256;
            if (enable === 1'b1) begin
              phase = 0; age = 0; entered = 1'b1;
            end else begin
              mode = MODE_IDLE;
            end
          end else begin
            phase = phase + 1; age = 0; entered = 1'b1;
          end
        end
      end else if (mode == MODE_EMERG) begin
        mode = MODE_RUN; phase = 0; age = 0; entered = 1'b1;
      end
    end
    m_mode    <= mode;
    m_phase   <= phase;
    m_age     <= age;
    m_rounds  <= rounds;
    m_entered <= entered;
  end

  // Compare every cycle once the model has seen a reset.
  initial begin : compareProc
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checkOutput("ns_light",  {29'd0, ns_light}, {29'd0, lampFor(0)});
        checkOutput("ew_light",  {29'd0, ew_light}, {29'd0, lampFor(1)});
        checkOutput("start_20s", {31'd0, start_20s}, {31'd0, m_entered && (m_phase % 2 == 0)});
        checkOutput("start_10s", {31'd0, start_10s}, {31'd0, m_entered && (m_phase % 2 == 1)});
        checkOutput("fault",     {31'd0, fault}, {31'd0, m_mode == MODE_FAULT});
        checkOutput("round_cnt", {24'd0, round_cnt}, 32'(m_rounds));
      end
    end
  end

  // Guards against a hung run.
  initial begin : globalTimeout
    #800_000;
    failures++;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed scenarios followed by a randomized stretch.
  initial begin : stimulus
`ifdef TPC_EMERGENCY_EN
    int emHold;
    emHold = 0;
`endif
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_ns",  {29'd0, ns_light}, 32'h4);
    checkOutput("reset_ew",  {29'd0, ew_light}, 32'h4);
    checkOutput("reset_s10", {31'd0, start_10s}, 32'd0);
    checkOutput("reset_s20", {31'd0, start_20s}, 32'd0);
    checkOutput("reset_fault", {31'd0, fault}, 32'd0);
    checkOutput("reset_round", {24'd0, round_cnt}, 32'd0);

    $display("[TB] nominal round with 10/20 cycle timer");
    applyStimulus(1'b0, 1'b1);
    checkOutput("nsg_entry_lamp", {29'd0, ns_light}, 32'h1);
    checkOutput("nsg_entry_s20", {31'd0, start_20s}, 32'd1);
    stepCycles(19);
    checkOutput("nsg_last_cycle", {29'd0, ns_light}, 32'h1);
    stepCycles(1);
    checkOutput("nsy_entry_lamp", {29'd0, ns_light}, 32'h2);
    checkOutput("nsy_entry_s10", {31'd0, start_10s}, 32'd1);
    stepCycles(10);
    checkOutput("ewg_entry_ew", {29'd0, ew_light}, 32'h1);
    checkOutput("ewg_entry_ns", {29'd0, ns_light}, 32'h4);
    stepCycles(20);
    checkOutput("ewy_entry_ew", {29'd0, ew_light}, 32'h2);
    stepCycles(10);
    checkOutput("round1_cnt", {24'd0, round_cnt}, 32'd1);
    checkOutput("round1_restart", {31'd0, start_20s}, 32'd1);

    $display("[TB] enable dropped during NS yellow");
    waitLamps(3'b010, 3'b100, 40, "reach_ns_y");
    applyStimulus(1'b0, 1'b0);
    waitLamps(3'b100, 3'b100, 80, "idle_after_drop");
    checkOutput("drop_round", {24'd0, round_cnt}, 32'd2);
    stepCycles(5);
    checkOutput("drop_stays_idle", {26'd0, ns_light, ew_light}, 32'h24);

    $display("[TB] reset mid-phase");
    applyStimulus(1'b0, 1'b1);
    stepCycles(3);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midreset_ns", {29'd0, ns_light}, 32'h4);
    checkOutput("midreset_s20", {31'd0, start_20s}, 32'd0);
    checkOutput("midreset_round", {24'd0, round_cnt}, 32'd0);

    $display("[TB] spurious done pulses during NS green");
    echo20  = 1'b1;
    noise10 = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("spur_nsg_entry", {29'd0, ns_light}, 32'h1);
    stepCycles(19);
    checkOutput("spur_nsg_held", {29'd0, ns_light}, 32'h1);
    stepCycles(1);
    checkOutput("spur_nsy_entry", {29'd0, ns_light}, 32'h2);
    echo20  = 1'b0;
    noise10 = 1'b0;

    $display("[TB] watchdog with silent timer");
    timer_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wdog_start", {31'd0, start_20s}, 32'd1);
    stepCycles(50);
    checkOutput("wdog_not_yet", {31'd0, fault}, 32'd0);
    stepCycles(1);
    checkOutput("wdog_fault", {31'd0, fault}, 32'd1);
    checkOutput("wdog_all_red", {26'd0, ns_light, ew_light}, 32'h24);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("fault_sticky", {31'd0, fault}, 32'd1);
    checkOutput("fault_no_start", {31'd0, start_20s}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("fault_cleared", {31'd0, fault}, 32'd0);
    timer_en = 1'b1;

    $display("[TB] 256 short rounds");
    dur10 = 2;
    dur20 = 2;
    applyStimulus(1'b0, 1'b1);
    stepCycles(8 * 255);
    checkOutput("round_255", {24'd0, round_cnt}, 32'd255);
    stepCycles(8);
    checkOutput("round_wrap", {24'd0, round_cnt}, 32'd0);

`ifdef TPC_EMERGENCY_EN
    $display("[TB] emergency during EW green");
    dur10 = 10;
    dur20 = 20;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitLamps(3'b100, 3'b001, 60, "reach_ew_g");
    emergency = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("emerg_all_red", {26'd0, ns_light, ew_light}, 32'h24);
    checkOutput("emerg_no_starts", {30'd0, start_10s, start_20s}, 32'd0);
    stepCycles(3);
    checkOutput("emerg_held_red", {26'd0, ns_light, ew_light}, 32'h24);
    checkOutput("emerg_held_quiet", {30'd0, start_10s, start_20s}, 32'd0);
    emergency = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("emerg_release_ns", {29'd0, ns_light}, 32'h1);
    checkOutput("emerg_release_s20", {31'd0, start_20s}, 32'd1);
    stepCycles(1);
    checkOutput("emerg_s20_once", {31'd0, start_20s}, 32'd0);
    checkOutput("emerg_round_kept", {24'd0, round_cnt}, 32'd0);
`endif

    $display("[TB] randomized run");
    applyStimulus(1'b1, 1'b0);
    noise_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(31) == 0) begin
        dur10 = int'($urandom_range(6, 1));
        dur20 = int'($urandom_range(8, 1));
      end
`ifdef TPC_EMERGENCY_EN
      if (emHold > 0) begin
        emHold--;
        emergency = 1'b1;
      end else begin
        emergency = ($urandom_range(149) == 0);
        if (emergency) emHold = int'($urandom_range(4));
      end
`endif
      applyStimulus($urandom_range(149) == 0, $urandom_range(9) != 0);
    end
    noise_en = 1'b0;
`ifdef TPC_EMERGENCY_EN
    emergency = 1'b0;
`endif
    applyStimulus(1'b1, 1'b0);
    stepCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Traffic-light phase sequencer that drives the dual-interval timer. It issues one-cycle `start_10s` / `start_20s` requests and advances phases on the matching `done_10s` / `done_20s` pulses. It drives the north-south and east-west lamp outputs and supervises the timer with a watchdog. It sits between the board inputs (switches and buttons) and the lamp LEDs, alongside the timer instance.

## Interface
- `WDOG_CYCLES`, default 32'd2_100_000_000: maximum cycles from a start pulse to the matching done before faulting. The bench overrides it to a small value.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: run request. Low means park in all-red.
- `emergency` in 1: all-red hold request. Present only with `TPC_EMERGENCY_EN`.
- `done_10s` in 1: one-cycle pulse from the timer when the 10 s interval ends.
- `done_20s` in 1: one-cycle pulse from the timer when the 20 s interval ends.
- `start_10s` out 1: one-cycle request to (re)start the 10 s interval.
- `start_20s` out 1: one-cycle request to (re)start the 20 s interval.
- `ns_light` out 3: north-south lamps as {red, yellow, green}, one-hot.
- `ew_light` out 3: east-west lamps as {red, yellow, green}, one-hot.
- `fault` out 1: sticky watchdog fault flag.
- `round_cnt` out 8: count of completed full NS+EW rounds, wraps at 255 to 0.

## Operation
- States:
  - IDLE: NS=R, EW=R.
  - NS_G: NS=G, EW=R; 20 s.
  - NS_Y: NS=Y, EW=R; 10 s.
  - EW_G: EW=G, NS=R; 20 s.
  - EW_Y: EW=Y, NS=R; 10 s.
  - FAULT: NS=R, EW=R.
  - EMERG: NS=R, EW=R; only with the macro.
- IDLE -> NS_G when `enable`=1.
- NS_G -> NS_Y on `done_20s`.
- NS_Y -> EW_G on `done_10s`.
- EW_G -> EW_Y on `done_20s`.
- EW_Y completes on `done_10s`:
  - `round_cnt` increments (mod 256).
  - Next state is NS_G if `enable`=1, else IDLE.
- `enable` is sampled only at EW_Y completion and in IDLE; a mid-round drop finishes the round.
- On entry to each timed state, assert exactly one start pulse: `start_20s` for the G states, `start_10s` for the Y states. Never assert both in the same cycle.
- A state listens only to its own done line. The other done line is ignored, including stale pulses from an aborted interval.
- An internal `waiting` flag is set the cycle after the start pulse. Done pulses while `waiting`=0 are ignored, including a done coincident with the start cycle.
- Watchdog:
  - A 32-bit counter clears on every start pulse and increments while `waiting`=1.
  - Reaching `WDOG_CYCLES` without the matching done -> FAULT, with `fault`=1.
- FAULT is terminal; only `rst` exits it. No start pulses are issued in FAULT.

## Timing
- Reset values:
  - state=IDLE.
  - `ns_light`=`ew_light`=3'b100.
  - `start_10s`=`start_20s`=0.
  - `fault`=0, `round_cnt`=0.
  - watchdog=0, `waiting`=0.
- All outputs are registered. Lamp outputs change on the same edge as the state register.
- Start pulses are high during the first cycle the new state is held, and high for exactly 1 cycle.
- A done pulse sampled high on edge N moves the state on edge N, so the new lamps are visible from N.
- IDLE with `enable`=1: NS_G is entered on the next edge and `start_20s` is high in that first NS_G cycle.
- Back-to-back phases: the start pulse of the next phase immediately follows the done of the previous phase, with no idle cycle.
- Priority per cycle, highest first:
  1. `rst`
  2. watchdog expiry
  3. `emergency` (macro)
  4. matching done
  5. `enable`
- Reset asserted mid-phase: IDLE on the next edge. No start pulse is issued in that cycle.

## Configuration
- `TPC_EMERGENCY_EN` defined:
  - The `emergency` port exists.
  - `emergency`=1 in any state except FAULT -> EMERG on the next edge. No start pulses; `waiting` and the watchdog are cleared.
  - Release -> NS_G, with a fresh `start_20s`.
  - `round_cnt` is unchanged by an emergency.
- `TPC_EMERGENCY_EN` undefined:
  - No `emergency` port and no EMERG state.
  - Behaviour is otherwise identical.

## Test plan
- Reset, then `enable`=1, with the timer model set to 10/20 cycles: observe the sequence
  - NS=G with `start_20s` at cycle 1
  - NS=Y with `start_10s` after 20 cycles
  - EW=G, then EW=Y
  - `round_cnt`=1 after 60 cycles plus pipeline.
- `enable` dropped during NS_Y: the round completes through EW_Y, then IDLE with both lamps R; `round_cnt` increments by exactly 1.
- Spurious `done_10s` injected during NS_G, and `done_20s` coincident with its own start cycle: no state change; the phase ends only on the genuine `done_20s`.
- Timer model never returns done, with `WDOG_CYCLES`=50:
  - FAULT 50 cycles after `start_20s`, with `fault`=1 and all red.
  - Toggling `enable` has no effect; `rst` clears the fault.
- `round_cnt` forced through 256 rounds (short timer): wraps 255 -> 0.
- With `TPC_EMERGENCY_EN`, `emergency` pulsed during EW_G:
  - All red on the next edge, with no start pulses while held.
  - On release: NS_G with `start_20s`=1 for one cycle.
  - `round_cnt` unchanged.
